// File: rtl/multdiv_sequencer.sv
// Sequences one MULT/DIV request through the shared multdiv unit and returns a one-cycle writeback.
// Optional watchdog abort when built with MULTDIV_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module multdiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RD_W           = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_is_div,
  input  logic [31:0]     req_a,
  input  logic [15:0]     req_b,
  input  logic [RD_W-1:0] req_rd,
  output logic            req_ready,
  input  logic            flush,
  output logic            stall,
  output logic            wb_valid,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_exception,
  output logic [31:0]     md_operandA,
  output logic [15:0]     md_operandB,
  output logic            md_ctrl_MULT,
  output logic            md_ctrl_DIV,
  input  logic [31:0]     md_result,
  input  logic            md_exception,
  input  logic            md_inputRDY,
  input  logic            md_resultRDY
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  state_t state, state_next;
  logic   is_div;
  logic   in_flight;
  logic   accept;
  logic   complete;
  logic   timeout_hit;
  logic   timeout_abort;

  assign in_flight = (state == ISSUE) || (state == BUSY);
  assign accept    = (state == IDLE) && req_valid && !flush;
  assign complete  = (state == BUSY) && md_resultRDY && !flush;

  // A timeout only fires when the RDY awaited in the current state is still absent.
  assign timeout_abort = timeout_hit && !flush &&
                         (((state == ISSUE) && !md_inputRDY) ||
                          ((state == BUSY) && !md_resultRDY));

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] timeout_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_cnt <= '0;
    end else if (accept) begin
      timeout_cnt <= '0;
    end else if (in_flight) begin
      timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = in_flight && (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = ISSUE;
      ISSUE: begin
        if (flush)              state_next = IDLE;
        else if (md_inputRDY)   state_next = BUSY;
        else if (timeout_abort) state_next = DONE;
      end
      BUSY: begin
        if (flush)              state_next = IDLE;
        else if (md_resultRDY)  state_next = DONE;
        else if (timeout_abort) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Controls are pure state decodes, so both drop on the edge leaving ISSUE/BUSY.
  always_comb begin
    req_ready    = (state == IDLE);
    stall        = (state != IDLE);
    wb_valid     = (state == DONE) && (wb_rd != '0);
    md_ctrl_MULT = in_flight && !is_div;
    md_ctrl_DIV  = in_flight && is_div;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      md_operandA  <= '0;
      md_operandB  <= '0;
      is_div       <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
    end else begin
      if (accept) begin
        md_operandA <= req_a;
        md_operandB <= req_b;
        is_div      <= req_is_div;
        wb_rd       <= req_rd;
      end
      if (complete) begin
        wb_data      <= md_result;
        wb_exception <= md_exception;
      end else if (timeout_abort) begin
        wb_data      <= '0;
        wb_exception <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer; the watchdog scenario runs only when MULTDIV_TIMEOUT_EN is defined.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_is_div, flush;
  logic [31:0] req_a;
  logic [15:0] req_b;
  logic [4:0]  req_rd;
  logic        req_ready, stall, wb_valid, wb_exception;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [31:0] md_operandA;
  logic [15:0] md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception, md_inputRDY, md_resultRDY;

  int tests_run  = 0;
  int fail_count = 0;

  multdiv_sequencer #(.TIMEOUT_CYCLES(8), .RD_W(5)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_is_div(req_is_div), .req_a(req_a), .req_b(req_b),
    .req_rd(req_rd), .req_ready(req_ready), .flush(flush), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_exception(wb_exception),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception),
    .md_inputRDY(md_inputRDY), .md_resultRDY(md_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic mult, input logic div);
    check({tag, ".mult"}, {31'd0, md_ctrl_MULT}, {31'd0, mult});
    check({tag, ".div"},  {31'd0, md_ctrl_DIV},  {31'd0, div});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, ".stall"},     {31'd0, stall},     32'd0);
    check({tag, ".wb_valid"},  {31'd0, wb_valid},  32'd0);
    check({tag, ".wb_data"},   wb_data,            32'd0);
    check({tag, ".wb_rd"},     {27'd0, wb_rd},     32'd0);
    check({tag, ".wb_exc"},    {31'd0, wb_exception}, 32'd0);
    check({tag, ".opA"},       md_operandA,        32'd0);
    check({tag, ".opB"},       {16'd0, md_operandB}, 32'd0);
    check_ctrl(tag, 1'b0, 1'b0);
  endtask

  task automatic send_req(input logic is_div, input logic [31:0] a, input logic [15:0] b, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_is_div = is_div;
    req_a      = a;
    req_b      = b;
    req_rd     = rd;
    step();
    req_valid  = 1'b0;
  endtask

  initial begin
    int cycles;
    reset = 1'b1; req_valid = 0; req_is_div = 0; req_a = 0; req_b = 0; req_rd = 0; flush = 0;
    md_result = 0; md_exception = 0; md_inputRDY = 0; md_resultRDY = 0;
    step(); step();
    check_reset_values("reset");
    reset = 1'b0;

    // MULT 7*6 -> rd 3
    send_req(1'b0, 32'd7, 16'd6, 5'd3);
    check("mul.stall", {31'd0, stall}, 32'd1);
    check("mul.ready", {31'd0, req_ready}, 32'd0);
    check("mul.opA", md_operandA, 32'd7);
    check("mul.opB", {16'd0, md_operandB}, 32'd6);
    check_ctrl("mul.issue", 1'b1, 1'b0);
    md_inputRDY = 1'b1;
    step();
    md_inputRDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_ctrl("mul.busy", 1'b1, 1'b0);
      check("mul.busy_wb", {31'd0, wb_valid}, 32'd0);
      step();
    end
    md_result = 32'd42; md_resultRDY = 1'b1;
    step();
    md_resultRDY = 1'b0; md_result = 32'hDEAD_BEEF;
    check("mul.wb_valid", {31'd0, wb_valid}, 32'd1);
    check("mul.wb_data", wb_data, 32'd42);
    check("mul.wb_rd", {27'd0, wb_rd}, 32'd3);
    check("mul.wb_exc", {31'd0, wb_exception}, 32'd0);
    check("mul.done_stall", {31'd0, stall}, 32'd1);
    check("mul.done_ready", {31'd0, req_ready}, 32'd0);
    check_ctrl("mul.done", 1'b0, 1'b0);
    // A request offered in DONE must not be taken
    send_req(1'b1, 32'd1, 16'd1, 5'd9);
    check("mul.idle_stall", {31'd0, stall}, 32'd0);
    check("mul.idle_ready", {31'd0, req_ready}, 32'd1);
    check("mul.idle_wb", {31'd0, wb_valid}, 32'd0);
    check_ctrl("mul.no_accept_in_done", 1'b0, 1'b0);

    // DIV 100/0 -> exception
    send_req(1'b1, 32'd100, 16'd0, 5'd9);
    check_ctrl("div0.issue", 1'b0, 1'b1);
    check("div0.opA", md_operandA, 32'd100);
    md_inputRDY = 1'b1;
    step();
    md_inputRDY = 1'b0;
    check_ctrl("div0.busy", 1'b0, 1'b1);
    md_result = 32'd0; md_exception = 1'b1; md_resultRDY = 1'b1;
    step();
    md_resultRDY = 1'b0; md_exception = 1'b0;
    check("div0.wb_valid", {31'd0, wb_valid}, 32'd1);
    check("div0.wb_exc", {31'd0, wb_exception}, 32'd1);
    check("div0.wb_rd", {27'd0, wb_rd}, 32'd9);
    check_ctrl("div0.done", 1'b0, 1'b0);
    step();

    // Flush in the second BUSY cycle of a DIV, then MULT 3*5
    send_req(1'b1, 32'd50, 16'd7, 5'd4);
    md_inputRDY = 1'b1;
    step();
    md_inputRDY = 1'b0;
    check_ctrl("flush.busy1", 1'b0, 1'b1);
    step();
    check_ctrl("flush.busy2", 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_ctrl("flush.after", 1'b0, 1'b0);
    check("flush.ready", {31'd0, req_ready}, 32'd1);
    check("flush.wb", {31'd0, wb_valid}, 32'd0);
    send_req(1'b0, 32'd3, 16'd5, 5'd7);
    check("flush.next_wb", {31'd0, wb_valid}, 32'd0);
    check_ctrl("m15.issue", 1'b1, 1'b0);
    md_result = 32'd99; md_resultRDY = 1'b1;
    step();
    md_resultRDY = 1'b0;
    check("m15.rdy_in_issue_stall", {31'd0, stall}, 32'd1);
    check("m15.rdy_in_issue_wb", {31'd0, wb_valid}, 32'd0);
    check_ctrl("m15.still_issue", 1'b1, 1'b0);
    md_inputRDY = 1'b1;
    step();
    md_inputRDY = 1'b0;
    md_result = 32'd15; md_resultRDY = 1'b1;
    step();
    md_resultRDY = 1'b0;
    check("m15.wb_valid", {31'd0, wb_valid}, 32'd1);
    check("m15.wb_data", wb_data, 32'd15);
    check("m15.wb_rd", {27'd0, wb_rd}, 32'd7);
    step();

    // Reset during ISSUE, then request together with flush in IDLE
    send_req(1'b0, 32'd11, 16'd2, 5'd5);
    check_ctrl("rst.issue", 1'b1, 1'b0);
    reset = 1'b1;
    step();
    check_reset_values("rst.mid_op");
    reset = 1'b0;
    flush = 1'b1;
    send_req(1'b1, 32'd77, 16'd3, 5'd8);
    flush = 1'b0;
    check_reset_values("rst.flushed_req");
    step();
    check_reset_values("rst.flushed_req2");

    // rd = 0: completes silently
    send_req(1'b0, 32'd2, 16'd2, 5'd0);
    md_inputRDY = 1'b1;
    step();
    md_inputRDY = 1'b0;
    md_result = 32'd4; md_resultRDY = 1'b1;
    step();
    md_resultRDY = 1'b0;
    check("rd0.done_stall", {31'd0, stall}, 32'd1);
    check("rd0.wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rd0.wb_data", wb_data, 32'd4);
    step();
    check("rd0.stall_release", {31'd0, stall}, 32'd0);
    check("rd0.ready", {31'd0, req_ready}, 32'd1);

`ifdef MULTDIV_TIMEOUT_EN
    // Watchdog: resultRDY never arrives
    send_req(1'b0, 32'd9, 16'd9, 5'd6);
    md_inputRDY = 1'b1;
    cycles = 0;
    while (!wb_valid && cycles < 20) begin
      if (md_ctrl_MULT) cycles++;
      step();
      md_inputRDY = 1'b0;
    end
    check("tmo.cycles", cycles, 32'd8);
    check("tmo.wb_valid", {31'd0, wb_valid}, 32'd1);
    check("tmo.wb_exc", {31'd0, wb_exception}, 32'd1);
    check("tmo.wb_data", wb_data, 32'd0);
    check_ctrl("tmo.done", 1'b0, 1'b0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
